// File: rtl/net_tx_arbiter_pkg.sv
// net_tx_arbiter_pkg: shared network-layer transmit definitions.
//   - arb_state_e      : arbiter FSM states (IDLE/XFER/DRAIN/GAP)
//   - GRANT_ARP/IP     : bit index of each source in the one-hot grant
//   - ETH_* defaults   : default frame-length limit and inter-frame gap
package net_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XFER  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_GAP   = 2'd3
  } arb_state_e;

  localparam int GRANT_ARP = 0;
  localparam int GRANT_IP  = 1;

  localparam int ETH_MAX_FRAME_BYTES = 1514;
  localparam int ETH_IFG_CYCLES      = 2;

endpackage

// File: rtl/net_tx_rr_pick.sv
// net_tx_rr_pick: combinational two-requester round-robin pick.
//   req[1:0]    : requests, bit GRANT_ARP / GRANT_IP
//   last_served : source granted most recently (1 = IP, 0 = ARP)
//   gnt[1:0]    : one-hot pick, 0 when nobody requests
// On a tie the source that was not served last wins.
module net_tx_rr_pick
  import net_tx_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_served,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_served == 1'(GRANT_IP)) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/net_tx_arbiter.sv
// net_tx_arbiter: packet-granular ARP/IP arbiter in front of the MAC tx FIFO.
//   logic_clk/logic_rstn           : clock, synchronous active-low reset
//   arp_t*                         : ARP source stream (valid/ready/last/data)
//   ip_t*                          : IP source stream
//   net_tmac_*                     : merged stream towards the MAC
//   arb_grant_out                  : one-hot grant, [0]=ARP [1]=IP, 0 in IDLE/GAP
//   arb_err_out                    : one-cycle pulse after a frame is truncated
// A grant is held first beat..tlast; frames longer than MAX_FRAME_BYTES are cut
// (forced last) and the rest of the source frame is swallowed in DRAIN.
// IFG_CYCLES idle cycles follow every frame.
// Optional macro NET_TX_ARBITER_STATS_EN adds 16-bit wrap-around counters
// arb_arp_frames_out, arb_ip_frames_out, arb_trunc_frames_out.
module net_tx_arbiter
  import net_tx_arbiter_pkg::*;
#(
  parameter int TDATA_WIDTH     = 8,
  parameter int IFG_CYCLES      = ETH_IFG_CYCLES,
  parameter int MAX_FRAME_BYTES = ETH_MAX_FRAME_BYTES
) (
  input  logic                   logic_clk,
  input  logic                   logic_rstn,
  input  logic [TDATA_WIDTH-1:0] arp_tdata_in,
  input  logic                   arp_tvalid_in,
  output logic                   arp_tready_out,
  input  logic                   arp_tlast_in,
  input  logic [TDATA_WIDTH-1:0] ip_tdata_in,
  input  logic                   ip_tvalid_in,
  output logic                   ip_tready_out,
  input  logic                   ip_tlast_in,
  output logic [TDATA_WIDTH-1:0] net_tmac_data_out,
  output logic                   net_tmac_valid_out,
  input  logic                   net_tmac_ready_in,
  output logic                   net_tmac_last_out,
  output logic [1:0]             arb_grant_out,
  output logic                   arb_err_out
`ifdef NET_TX_ARBITER_STATS_EN
  ,
  output logic [15:0]            arb_arp_frames_out,
  output logic [15:0]            arb_ip_frames_out,
  output logic [15:0]            arb_trunc_frames_out
`endif
);

  localparam int BW = $clog2(MAX_FRAME_BYTES + 1);
  localparam int GW = (IFG_CYCLES > 0) ? $clog2(IFG_CYCLES + 1) : 1;
  localparam logic [BW-1:0] BEAT_LAST = BW'(MAX_FRAME_BYTES - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);
  // Frame end goes straight back to arbitration when no gap is configured.
  localparam arb_state_e END_STATE = (IFG_CYCLES > 0) ? ST_GAP : ST_IDLE;

  arb_state_e        state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic              last_q, last_d;     // 1 = IP served last
  logic [BW-1:0]     beat_cnt_q, beat_cnt_d;
  logic [GW-1:0]     gap_cnt_q, gap_cnt_d;
  logic              err_q, err_d;

  logic [1:0]             pick;
  logic                   sel_ip;
  logic                   src_tvalid, src_tlast, src_tready, src_hs;
  logic [TDATA_WIDTH-1:0] src_tdata;
  logic                   in_xfer, in_drain, force_last;

  net_tx_rr_pick u_pick (
    .req         ({ip_tvalid_in, arp_tvalid_in}),
    .last_served (last_q),
    .gnt         (pick)
  );

  // Datapath: pure mux of the granted source, no storage.
  always_comb begin
    sel_ip     = grant_q[GRANT_IP];
    src_tvalid = sel_ip ? ip_tvalid_in : arp_tvalid_in;
    src_tlast  = sel_ip ? ip_tlast_in  : arp_tlast_in;
    src_tdata  = sel_ip ? ip_tdata_in  : arp_tdata_in;
    in_xfer    = (state_q == ST_XFER);
    in_drain   = (state_q == ST_DRAIN);
    force_last = (beat_cnt_q == BEAT_LAST) && !src_tlast;
    // DRAIN accepts unconditionally so the cut-off tail is discarded.
    src_tready = in_xfer ? net_tmac_ready_in : in_drain;
    src_hs     = src_tvalid && src_tready && (grant_q != 2'b00);

    arp_tready_out     = src_tready && grant_q[GRANT_ARP];
    ip_tready_out      = src_tready && grant_q[GRANT_IP];
    net_tmac_valid_out = in_xfer && src_tvalid;
    net_tmac_data_out  = in_xfer ? src_tdata : '0;
    net_tmac_last_out  = in_xfer && src_tvalid && (src_tlast || force_last);
    arb_grant_out      = grant_q;
    arb_err_out        = err_q;
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    beat_cnt_d = beat_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    err_d      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pick != 2'b00) begin
          grant_d    = pick;
          last_d     = pick[GRANT_IP];
          beat_cnt_d = '0;
          state_d    = ST_XFER;
        end
      end
      ST_XFER: begin
        if (src_hs) begin
          if (src_tlast) begin
            beat_cnt_d = '0;
            gap_cnt_d  = '0;
            grant_d    = 2'b00;
            state_d    = END_STATE;
          end else if (force_last) begin
            beat_cnt_d = '0;
            err_d      = 1'b1;
            state_d    = ST_DRAIN;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (src_hs && src_tlast) begin
          gap_cnt_d = '0;
          grant_d   = 2'b00;
          state_d   = END_STATE;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) state_d = ST_IDLE;
        else                       gap_cnt_d = gap_cnt_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge logic_clk) begin
    if (!logic_rstn) begin
      state_q    <= ST_IDLE;
      grant_q    <= 2'b00;
      last_q     <= 1'(GRANT_IP);
      beat_cnt_q <= '0;
      gap_cnt_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      beat_cnt_q <= beat_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      err_q      <= err_d;
    end
  end

`ifdef NET_TX_ARBITER_STATS_EN
  logic [15:0] arp_frames_q, arp_frames_d;
  logic [15:0] ip_frames_q, ip_frames_d;
  logic [15:0] trunc_q, trunc_d;
  logic        frame_end;

  // A frame of a source is counted when its last output beat (real or forced)
  // is accepted.
  always_comb begin
    frame_end    = in_xfer && src_hs && (src_tlast || force_last);
    arp_frames_d = arp_frames_q + 16'(frame_end && grant_q[GRANT_ARP]);
    ip_frames_d  = ip_frames_q  + 16'(frame_end && grant_q[GRANT_IP]);
    trunc_d      = trunc_q      + 16'(err_d);
  end

  always_ff @(posedge logic_clk) begin
    if (!logic_rstn) begin
      arp_frames_q <= '0;
      ip_frames_q  <= '0;
      trunc_q      <= '0;
    end else begin
      arp_frames_q <= arp_frames_d;
      ip_frames_q  <= ip_frames_d;
      trunc_q      <= trunc_d;
    end
  end

  assign arb_arp_frames_out   = arp_frames_q;
  assign arb_ip_frames_out    = ip_frames_q;
  assign arb_trunc_frames_out = trunc_q;
`endif

endmodule

// File: tb/tb_net_tx_arbiter.sv
// tb_net_tx_arbiter: directed + randomized checks of net_tx_arbiter.
// Frames are queued per source as {last,data} beats; the expected MAC stream
// is derived from the queued frames by walking them in round-robin frame
// order and applying the length limit.
module tb_net_tx_arbiter;
  localparam int W    = 8;
  localparam int IFG  = 2;
  localparam int MAXB = 64;

  logic         clk = 1'b0;
  logic         logic_rstn;
  logic [W-1:0] arp_tdata_in, ip_tdata_in, net_tmac_data_out;
  logic         arp_tvalid_in, arp_tready_out, arp_tlast_in;
  logic         ip_tvalid_in, ip_tready_out, ip_tlast_in;
  logic         net_tmac_valid_out, net_tmac_ready_in, net_tmac_last_out;
  logic [1:0]   arb_grant_out;
  logic         arb_err_out;
`ifdef NET_TX_ARBITER_STATS_EN
  logic [15:0]  arp_fr, ip_fr, tr_fr;
`endif

  always #5 clk = ~clk;

  net_tx_arbiter #(.TDATA_WIDTH(W), .IFG_CYCLES(IFG), .MAX_FRAME_BYTES(MAXB)) dut (
    .logic_clk(clk), .logic_rstn(logic_rstn),
    .arp_tdata_in(arp_tdata_in), .arp_tvalid_in(arp_tvalid_in),
    .arp_tready_out(arp_tready_out), .arp_tlast_in(arp_tlast_in),
    .ip_tdata_in(ip_tdata_in), .ip_tvalid_in(ip_tvalid_in),
    .ip_tready_out(ip_tready_out), .ip_tlast_in(ip_tlast_in),
    .net_tmac_data_out(net_tmac_data_out), .net_tmac_valid_out(net_tmac_valid_out),
    .net_tmac_ready_in(net_tmac_ready_in), .net_tmac_last_out(net_tmac_last_out),
    .arb_grant_out(arb_grant_out), .arb_err_out(arb_err_out)
`ifdef NET_TX_ARBITER_STATS_EN
    , .arb_arp_frames_out(arp_fr), .arb_ip_frames_out(ip_fr), .arb_trunc_frames_out(tr_fr)
`endif
  );

  int nvec = 0, nerr = 0;
  logic [8:0]  arp_q[$], ip_q[$];   // {last, data}
  logic [10:0] exp_q[$], obs_q[$];  // {grant, last, data}
  int gap_q[$];
  int exp_err, err_seen, cyc, zrun, m_last, ready_mode;
  bit bubble_en, chk_bp, rst_req, arp_mid, ip_mid, seen_frame;

  task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
    nvec++;
    assert (o === e) else begin
      nerr++;
      $error("FAIL %s: got %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic add_frame(int src, int len);
    for (int i = 0; i < len; i++) begin
      logic [8:0] b;
      b = {(i == len - 1), 8'($urandom)};
      if (src == 0) arp_q.push_back(b); else ip_q.push_back(b);
    end
  endtask

  // Reference: whole frames in round-robin order, first MAXB beats kept.
  task automatic build_exp();
    int ia, ii;
    ia = 0; ii = 0;
    exp_q.delete(); exp_err = 0;
    while (ia < arp_q.size() || ii < ip_q.size()) begin
      int src, n;
      bit done;
      logic [1:0] g;
      if (ia < arp_q.size() && ii < ip_q.size()) src = (m_last == 1) ? 0 : 1;
      else src = (ia < arp_q.size()) ? 0 : 1;
      m_last = src;
      g = (src == 0) ? 2'b01 : 2'b10;
      n = 0; done = 0;
      while (!done) begin
        logic [8:0] b;
        if (src == 0) begin b = arp_q[ia]; ia++; end
        else begin b = ip_q[ii]; ii++; end
        n++;
        if (n < MAXB) exp_q.push_back({g, b});
        else if (n == MAXB) begin
          exp_q.push_back({g, 1'b1, b[7:0]});
          if (!b[8]) exp_err++;
        end
        done = b[8];
      end
    end
  endtask

  task automatic clear_obs();
    obs_q.delete(); gap_q.delete();
    err_seen = 0; zrun = 0; seen_frame = 0;
  endtask

  task automatic cycle();
    @(negedge clk);
    cyc++;
    logic_rstn = !rst_req;
    arp_tvalid_in = (arp_q.size() > 0) && !(bubble_en && arp_mid && $urandom_range(3) == 0);
    ip_tvalid_in  = (ip_q.size() > 0)  && !(bubble_en && ip_mid  && $urandom_range(3) == 0);
    {arp_tlast_in, arp_tdata_in} = (arp_q.size() > 0) ? arp_q[0] : 9'h0;
    {ip_tlast_in, ip_tdata_in}   = (ip_q.size() > 0)  ? ip_q[0]  : 9'h0;
    case (ready_mode)
      0:       net_tmac_ready_in = 1'b1;
      1:       net_tmac_ready_in = (cyc % 2 == 0);
      default: net_tmac_ready_in = 1'($urandom_range(1));
    endcase
    #1;
    if (net_tmac_valid_out && net_tmac_ready_in)
      obs_q.push_back({arb_grant_out, net_tmac_last_out, net_tmac_data_out});
    if (arb_err_out) err_seen++;
    if (rst_req == 0) begin
      chk("grant_onehot", 32'($countones(arb_grant_out) <= 1), 32'd1);
      if (arb_grant_out != 2'b01) chk("arp_rdy_not_granted", 32'(arp_tready_out), 32'd0);
      if (arb_grant_out != 2'b10) chk("ip_rdy_not_granted", 32'(ip_tready_out), 32'd0);
      if (arb_grant_out == 2'b00) chk("valid_without_grant", 32'(net_tmac_valid_out), 32'd0);
      if (chk_bp && arb_grant_out == 2'b10)
        chk("ip_rdy_follows_mac", 32'(ip_tready_out), 32'(net_tmac_ready_in));
    end
    if (arb_grant_out == 2'b00) zrun++;
    else begin
      if (zrun > 0 && seen_frame) gap_q.push_back(zrun);
      zrun = 0; seen_frame = 1;
    end
    if (arp_tvalid_in && arp_tready_out) begin arp_mid = !arp_q[0][8]; void'(arp_q.pop_front()); end
    if (ip_tvalid_in && ip_tready_out)   begin ip_mid  = !ip_q[0][8];  void'(ip_q.pop_front());  end
  endtask

  task automatic run(string tag);
    int t;
    t = 0;
    while (!(arp_q.size() == 0 && ip_q.size() == 0 && obs_q.size() >= exp_q.size()) && t < 20000) begin
      cycle(); t++;
    end
    chk({tag, "_timeout"}, 32'(t < 20000), 32'd1);
    repeat (6) cycle();
    chk({tag, "_nbeats"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      chk($sformatf("%s_beat%0d", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
    chk({tag, "_errpulses"}, 32'(err_seen), 32'(exp_err));
  endtask

  task automatic chk_idle_outputs(string tag);
    chk({tag, "_valid"}, 32'(net_tmac_valid_out), 32'd0);
    chk({tag, "_last"},  32'(net_tmac_last_out), 32'd0);
    chk({tag, "_data"},  32'(net_tmac_data_out), 32'd0);
    chk({tag, "_arprdy"}, 32'(arp_tready_out), 32'd0);
    chk({tag, "_iprdy"},  32'(ip_tready_out), 32'd0);
    chk({tag, "_grant"}, 32'(arb_grant_out), 32'd0);
    chk({tag, "_err"},   32'(arb_err_out), 32'd0);
`ifdef NET_TX_ARBITER_STATS_EN
    chk({tag, "_stat_arp"}, 32'(arp_fr), 32'd0);
    chk({tag, "_stat_ip"},  32'(ip_fr), 32'd0);
    chk({tag, "_stat_tr"},  32'(tr_fr), 32'd0);
`endif
  endtask

  initial begin
    logic_rstn = 1'b0; rst_req = 1; ready_mode = 0; bubble_en = 0; chk_bp = 0;
    arp_tvalid_in = 0; ip_tvalid_in = 0; arp_tlast_in = 0; ip_tlast_in = 0;
    arp_tdata_in = '0; ip_tdata_in = '0; net_tmac_ready_in = 0;
    cyc = 0; m_last = 1; arp_mid = 0; ip_mid = 0;
    clear_obs();

    // Reset state
    repeat (3) cycle();
    chk_idle_outputs("reset");
    rst_req = 0;
    cycle();

    // Single ARP frame, 42 beats
    clear_obs(); add_frame(0, 42); build_exp(); run("arp42");

    // Round-robin: 3 frames per source queued together
    clear_obs();
    for (int f = 0; f < 3; f++) begin
      add_frame(0, $urandom_range(1, 20));
      add_frame(1, $urandom_range(1, 20));
    end
    build_exp(); run("rr");
    chk("rr_ngaps", 32'(gap_q.size()), 32'd5);
    foreach (gap_q[i]) chk($sformatf("rr_gap%0d", i), 32'(gap_q[i]), 32'(IFG + 1));

    // Backpressure: ready toggling 1010
    clear_obs(); ready_mode = 1; chk_bp = 1;
    add_frame(1, 60); build_exp(); run("bp60");
    chk_bp = 0; ready_mode = 0;

    // Truncation: 100-beat frame against a 64-beat limit
    clear_obs(); add_frame(1, 100); build_exp(); run("trunc100");

    // Boundaries: exactly MAXB beats, and a single-beat frame
    clear_obs(); add_frame(1, MAXB); build_exp(); run("exact64");
    clear_obs(); add_frame(0, 1); build_exp(); run("arp1");

    // Random traffic with backpressure and mid-frame valid bubbles
    ready_mode = 2; bubble_en = 1;
    for (int r = 0; r < 3; r++) begin
      clear_obs();
      for (int f = 0; f < 3; f++) begin
        add_frame(0, $urandom_range(1, 90));
        add_frame(1, $urandom_range(1, 90));
      end
      build_exp(); run($sformatf("rand%0d", r));
    end
    ready_mode = 0; bubble_en = 0;

    // Reset in the middle of a 40-beat ARP frame
    clear_obs(); add_frame(0, 40);
    begin
      int t;
      t = 0;
      while (obs_q.size() < 10 && t < 1000) begin cycle(); t++; end
      chk("midrst_reach_beat10", 32'(obs_q.size()), 32'd10);
    end
    rst_req = 1;
    cycle();
    cycle();
    chk_idle_outputs("midrst");
    arp_q.delete(); ip_q.delete();
    m_last = 1; arp_mid = 0; ip_mid = 0;
    rst_req = 0;
    cycle();
    clear_obs();
    add_frame(1, 5); add_frame(0, 5);
    build_exp(); run("post_rst_tie");
    chk("post_rst_first_grant", 32'(obs_q.size() > 0 ? obs_q[0][10:9] : 2'b00), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/net_tx_arbiter.md
Name: net_tx_arbiter

Overview:
- Packet-granular arbiter that shares the single network-to-MAC transmit stream between two sources: ARP frames (requests/replies) and IP frames (UDP payload from the transport layer).
- Sits inside the network layer, just before the MAC transmit FIFO input.
- A grant is held from the first beat until tlast, so frames are never interleaved.
- Also enforces a minimum idle gap between frames and a maximum frame length, with truncation and drain on overrun.

Parameters:
TDATA_WIDTH, 8, stream data width in bits
IFG_CYCLES, 2, idle cycles forced after every frame end (0 = none)
MAX_FRAME_BYTES, 1514, beat limit per frame before forced truncation

Ports:
logic_clk  in  1  single clock for all logic
logic_rstn  in  1  reset, synchronous, active-low
arp_tdata_in  in  TDATA_WIDTH  ARP source data
arp_tvalid_in  in  1  ARP source valid
arp_tready_out  out  1  ARP source ready
arp_tlast_in  in  1  ARP source last beat
ip_tdata_in  in  TDATA_WIDTH  IP source data
ip_tvalid_in  in  1  IP source valid
ip_tready_out  out  1  IP source ready
ip_tlast_in  in  1  IP source last beat
net_tmac_data_out  out  TDATA_WIDTH  to MAC transmit
net_tmac_valid_out  out  1  to MAC transmit
net_tmac_ready_in  in  1  from MAC transmit
net_tmac_last_out  out  1  to MAC transmit
arb_grant_out  out  2  one-hot current grant: [0]=ARP, [1]=IP
arb_err_out  out  1  one-cycle pulse on frame truncation

Behaviour:
- Reset: logic_clk and logic_rstn are one clock; reset is synchronous and active-low.
  - On reset: state=IDLE, grant=0, last_served=IP, beat_cnt=0, gap_cnt=0, arb_err_out=0.
  - All valid/ready outputs are 0; net_tmac_data_out=0.
  - Reset mid-frame aborts immediately; the partial frame is not terminated.
- States: IDLE, XFER, DRAIN, GAP.
- IDLE:
  - Only ARP valid: grant ARP. Only IP valid: grant IP.
  - Both valid: grant the source that is not last_served (round-robin). After reset, ARP wins a tie.
  - The grant register is set on the cycle after valid is sampled. Go to XFER and record last_served.
- XFER: datapath is a combinational pass-through of the granted source.
  - net_tmac_valid_out = src_tvalid; src_tready = net_tmac_ready_in; data passes through.
  - net_tmac_last_out = src_tlast OR force_last.
  - Non-granted source sees tready=0.
  - beat_cnt increments on each output handshake.
  - force_last = (beat_cnt == MAX_FRAME_BYTES-1) AND NOT src_tlast.
  - Handshake with src_tlast: go to GAP, or to IDLE if IFG_CYCLES=0. beat_cnt=0.
  - Handshake with force_last: pulse arb_err_out and go to DRAIN. beat_cnt=0.
- DRAIN:
  - net_tmac_valid_out=0; granted src_tready=1, so the remaining source beats are discarded.
  - On a src handshake with tlast: go to GAP/IDLE.
- GAP:
  - grant=0, all readies=0, valid_out=0.
  - Stay exactly IFG_CYCLES cycles, then go to IDLE.
- A source asserting valid during GAP is held off; it is arbitrated in IDLE.
- Source valid dropping mid-frame: the grant is held indefinitely, with no timeout.
- A 1-beat frame (tlast on the first beat) is legal and counts as a complete frame.
- Widths:
  - beat_cnt width = $clog2(MAX_FRAME_BYTES+1).
  - gap_cnt width = $clog2(IFG_CYCLES+1), minimum 1.
- arb_grant_out mirrors the grant register and is 0 in IDLE and GAP.

Optional Feature:
- Macro NET_TX_ARBITER_STATS_EN.
  - Defined: adds ports arb_arp_frames_out [15:0], arb_ip_frames_out [15:0] and arb_trunc_frames_out [15:0].
  - These are free-running wrap-around counters, incremented on each completed or truncated frame of that source, and on each truncation respectively.
  - All counters are reset to 0 by logic_rstn.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared net package holds:
  - the state enum (IDLE/XFER/DRAIN/GAP);
  - grant index constants GRANT_ARP=0, GRANT_IP=1;
  - default constants ETH_MAX_FRAME_BYTES=1514 and ETH_IFG_CYCLES.
- One sub-module, net_tx_rr_pick: a 2-requester round-robin pick, combinational, taking the last_served input.
- Counters and FSM stay in the top block.

Test Plan:
- Grant and ordering: ARP 42-beat frame alone, ready=1, IFG_CYCLES=2 → 42 output beats, last on beat 42, arb_grant_out=01, 2 idle cycles, then IDLE.
- Tie and round-robin: ARP and IP valid together after reset, back-to-back 3 frames each → order ARP, IP, ARP, IP, ARP, IP, with no interleaved beats.
- Backpressure: IP 60-beat frame, net_tmac_ready_in toggling 1010… → all 60 bytes in order, ip_tready_out equal to ready_in every cycle, no dropped or duplicated byte.
- Truncation: MAX_FRAME_BYTES=64, IP frame of 100 beats → 64 output beats, last on beat 64, arb_err_out pulses once, beats 65–100 drained with valid_out=0, then GAP.
- Boundary: frame of exactly 64 beats with MAX=64 → no error pulse, normal GAP. A 1-beat ARP frame → valid+last on the same beat.
- Reset mid-frame: drop logic_rstn at beat 10 of 40 → the next cycle all outputs are 0 and arb_grant_out=0; after release, ARP wins the next tie. With STATS_EN, counters read 0.
